// File: rtl/tournament_predictor_param.sv
// Tournament branch predictor: bimodal + gshare components chosen per PC by a
// chooser table, with a speculative global history register (GHR) that is
// repaired on mispredict. After reset an init sweep writes every table entry,
// so the table storage itself carries no reset.
module tournament_predictor_param #(
  parameter int PC_W     = 16,
  parameter int PC_LSB   = 0,
  parameter int IDX_BITS = 8,
  parameter int HIST_LEN = 8,
  parameter int CTR_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic                pred_valid,
  input  logic [PC_W-1:0]     pred_pc,
  output logic                pred_taken,
  output logic [HIST_LEN-1:0] pred_hist,
  input  logic                upd_valid,
  input  logic [PC_W-1:0]     upd_pc,
  input  logic [HIST_LEN-1:0] upd_hist,
  input  logic                upd_taken,
  input  logic                upd_mispredict
);

  localparam int DEPTH = 1 << IDX_BITS;

  // Counter constants: weak not-taken for the direction tables, weak gshare
  // for the chooser.
  localparam logic [CTR_W-1:0] CTR_ZERO    = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0] CTR_ONE     = {{(CTR_W-1){1'b0}}, 1'b1};
  localparam logic [CTR_W-1:0] CTR_MAX     = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CTR_WEAK_G  = {1'b1, {(CTR_W-1){1'b0}}};

  localparam logic [IDX_BITS-1:0] IDX_ZERO = {IDX_BITS{1'b0}};
  localparam logic [IDX_BITS-1:0] IDX_ONE  = {{(IDX_BITS-1){1'b0}}, 1'b1};
  localparam logic [IDX_BITS-1:0] IDX_LAST = {IDX_BITS{1'b1}};
  localparam logic [HIST_LEN-1:0] HIST_ZERO = {HIST_LEN{1'b0}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // Saturating one-step move toward the requested direction.
  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] ctr,
                                                input logic             up);
    logic [CTR_W-1:0] res;
    res = ctr;
    if (up) begin
      if (ctr != CTR_MAX) res = ctr + CTR_ONE;
      else                res = ctr;
    end else begin
      if (ctr != CTR_ZERO) res = ctr - CTR_ONE;
      else                 res = ctr;
    end
    return res;
  endfunction

  // Chooser moves toward whichever component was uniquely correct.
  function automatic logic [CTR_W-1:0] cho_step(input logic [CTR_W-1:0] ctr,
                                                input logic             bim_ok,
                                                input logic             gsh_ok);
    logic [CTR_W-1:0] res;
    res = ctr;
    if (gsh_ok && !bim_ok)      res = ctr_step(ctr, 1'b1);
    else if (bim_ok && !gsh_ok) res = ctr_step(ctr, 1'b0);
    else                        res = ctr;
    return res;
  endfunction

  // History zero-extended or truncated to the index width.
  function automatic logic [IDX_BITS-1:0] hist_to_idx(input logic [HIST_LEN-1:0] h);
    logic [HIST_LEN+IDX_BITS-1:0] ext;
    ext = {{IDX_BITS{1'b0}}, h};
    return ext[IDX_BITS-1:0];
  endfunction

  // Shift a new outcome into the history; degenerates to the new bit when
  // the history is one bit long.
  function automatic logic [HIST_LEN-1:0] hist_shift(input logic [HIST_LEN-1:0] h,
                                                     input logic              b);
    logic [HIST_LEN:0] ext;
    ext = {h, b};
    return ext[HIST_LEN-1:0];
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] sweep_idx_q, sweep_idx_d;
  logic [HIST_LEN-1:0] ghr_q, ghr_d;
  logic                ready_q, ready_d;

  logic [CTR_W-1:0] bim_q [DEPTH];
  logic [CTR_W-1:0] gsh_q [DEPTH];
  logic [CTR_W-1:0] cho_q [DEPTH];

  // Predict-side signals
  logic [IDX_BITS-1:0] pred_pidx_s, pred_gidx_s;
  logic                pred_bim_s, pred_gsh_s, pred_use_g_s, pred_taken_s;

  // Update-side signals
  logic [IDX_BITS-1:0] upd_pidx_s, upd_gidx_s;
  logic [CTR_W-1:0]    upd_bim_old_s, upd_gsh_old_s, upd_cho_old_s;
  logic [CTR_W-1:0]    upd_bim_new_s, upd_gsh_new_s, upd_cho_new_s;
  logic                upd_bim_ok_s, upd_gsh_ok_s, upd_en_s;

  // PC bits outside the index window do not take part in prediction.
  logic unused_pc_s;
  assign unused_pc_s = ^{pred_pc, upd_pc};

  // Control registers: FSM state, sweep pointer, GHR and ready flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      sweep_idx_q <= IDX_ZERO;
      ghr_q       <= HIST_ZERO;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      ghr_q       <= ghr_d;
      ready_q     <= ready_d;
    end
  end

  // Init sweep sequencing: walk every index once, then stay in RUN.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      ST_INIT: begin
        if (sweep_idx_q == IDX_LAST) begin
          state_d     = ST_RUN;
          sweep_idx_d = IDX_ZERO;
        end else begin
          state_d     = ST_INIT;
          sweep_idx_d = sweep_idx_q + IDX_ONE;
        end
      end
      ST_RUN: begin
        state_d     = ST_RUN;
        sweep_idx_d = IDX_ZERO;
      end
      default: begin
        state_d     = ST_INIT;
        sweep_idx_d = IDX_ZERO;
      end
    endcase
    ready_d = (state_d == ST_RUN);
  end

  // Combinational prediction from the current GHR and table contents.
  always_comb begin
    pred_pidx_s  = pred_pc[PC_LSB +: IDX_BITS];
    pred_gidx_s  = pred_pidx_s ^ hist_to_idx(ghr_q);
    pred_bim_s   = bim_q[pred_pidx_s][CTR_W-1];
    pred_gsh_s   = gsh_q[pred_gidx_s][CTR_W-1];
    pred_use_g_s = cho_q[pred_pidx_s][CTR_W-1];
    if (!ready_q)          pred_taken_s = 1'b0;
    else if (pred_use_g_s) pred_taken_s = pred_gsh_s;
    else                   pred_taken_s = pred_bim_s;
  end

  assign pred_taken = pred_taken_s;
  assign pred_hist  = ghr_q;
  assign ready      = ready_q;

  // Resolve-side lookup and next counter values, judged on pre-update state.
  always_comb begin
    upd_en_s      = upd_valid & ready_q;
    upd_pidx_s    = upd_pc[PC_LSB +: IDX_BITS];
    upd_gidx_s    = upd_pidx_s ^ hist_to_idx(upd_hist);
    upd_bim_old_s = bim_q[upd_pidx_s];
    upd_gsh_old_s = gsh_q[upd_gidx_s];
    upd_cho_old_s = cho_q[upd_pidx_s];
    upd_bim_ok_s  = (upd_bim_old_s[CTR_W-1] == upd_taken);
    upd_gsh_ok_s  = (upd_gsh_old_s[CTR_W-1] == upd_taken);
    upd_bim_new_s = ctr_step(upd_bim_old_s, upd_taken);
    upd_gsh_new_s = ctr_step(upd_gsh_old_s, upd_taken);
    upd_cho_new_s = cho_step(upd_cho_old_s, upd_bim_ok_s, upd_gsh_ok_s);
  end

  // GHR next value: mispredict repair beats the speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (!ready_q) begin
      ghr_d = ghr_q;
    end else if (upd_valid && upd_mispredict) begin
      ghr_d = hist_shift(upd_hist, upd_taken);
    end else if (pred_valid) begin
      ghr_d = hist_shift(ghr_q, pred_taken_s);
    end else begin
      ghr_d = ghr_q;
    end
  end

  // Table storage: init sweep writes one entry per clock, then resolves train.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      bim_q[sweep_idx_q] <= CTR_WEAK_NT;
      gsh_q[sweep_idx_q] <= CTR_WEAK_NT;
      cho_q[sweep_idx_q] <= CTR_WEAK_G;
    end else if (upd_en_s) begin
      bim_q[upd_pidx_s] <= upd_bim_new_s;
      gsh_q[upd_gidx_s] <= upd_gsh_new_s;
      cho_q[upd_pidx_s] <= upd_cho_new_s;
    end
  end

endmodule

// File: tb/tb_tournament_predictor_param.sv
// Bench for tournament_predictor_param (IDX_BITS=8, HIST_LEN=8, CTR_W=2).
// Reference model keeps the three tables as integer arrays and the GHR as an
// integer; every cycle the outputs are checked against it, plus directed
// expectations for the named scenarios.
module tb_tournament_predictor_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready;
  logic        pred_valid = 1'b0;
  logic [15:0] pred_pc = 16'h0000;
  logic        pred_taken;
  logic [7:0]  pred_hist;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_pc = 16'h0000;
  logic [7:0]  upd_hist = 8'h00;
  logic        upd_taken = 1'b0;
  logic        upd_mispredict = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  // reference model
  int m_bim [256];
  int m_gsh [256];
  int m_cho [256];
  int m_ghr;
  int m_edges;

  // last sampled DUT outputs (stimulus feedback only)
  logic       dut_pred;
  logic [7:0] dut_hist;

  tournament_predictor_param #(
    .PC_W(16), .PC_LSB(0), .IDX_BITS(8), .HIST_LEN(8), .CTR_W(2)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_hist(pred_hist),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_move(input int v, input bit up);
    if (up) return (v >= 3) ? 3 : v + 1;
    return (v <= 0) ? 0 : v - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_bim[i] = 1;
      m_gsh[i] = 1;
      m_cho[i] = 2;
    end
    m_ghr   = 0;
    m_edges = 0;
  endtask

  task automatic idle();
    pred_valid = 1'b0;
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  // Called at posedge+1; checks at negedge, advances model, returns at next posedge+1.
  task automatic cycle();
    bit exp_ready, exp_pred, b_ok, g_ok;
    int pi, gi, ui, ugi, b, g, c;
    @(negedge clk);
    exp_ready = (m_edges >= 256);
    pi = int'(pred_pc) & 255;
    gi = pi ^ m_ghr;
    if (!exp_ready)        exp_pred = 1'b0;
    else if (m_cho[pi] >= 2) exp_pred = (m_gsh[gi] >= 2);
    else                   exp_pred = (m_bim[pi] >= 2);
    dut_pred = pred_taken;
    dut_hist = pred_hist;
    check("ready", 32'(ready), 32'(exp_ready));
    check("pred_taken", 32'(pred_taken), 32'(exp_pred));
    check("pred_hist", 32'(pred_hist), m_ghr);
    if (exp_ready) begin
      if (upd_valid) begin
        ui  = int'(upd_pc) & 255;
        ugi = ui ^ int'(upd_hist);
        b = m_bim[ui]; g = m_gsh[ugi]; c = m_cho[ui];
        b_ok = ((b >= 2) == upd_taken);
        g_ok = ((g >= 2) == upd_taken);
        m_bim[ui]  = sat_move(b, upd_taken);
        m_gsh[ugi] = sat_move(g, upd_taken);
        if (g_ok && !b_ok)      m_cho[ui] = sat_move(c, 1'b1);
        else if (b_ok && !g_ok) m_cho[ui] = sat_move(c, 1'b0);
      end
      if (upd_valid && upd_mispredict)
        m_ghr = ((int'(upd_hist) << 1) | int'(upd_taken)) & 255;
      else if (pred_valid)
        m_ghr = ((m_ghr << 1) | int'(exp_pred)) & 255;
    end
    @(posedge clk);
    m_edges++;
    #1;
  endtask

  // Async reset pulse between edges; edge count restarts.
  task automatic reset_pulse();
    reset = 1'b1;
    #2;
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] h;
    logic       p;
    bit         outcome;
    int         tail_ok;

    model_reset();
    idle();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // 1. init sweep timing, with a restart at edge 100
    for (int i = 0; i < 100; i++) cycle();
    check("t1_not_ready_at_100", 32'(ready), 32'd0);
    reset_pulse();
    for (int i = 0; i < 255; i++) cycle();
    check("t1_not_ready_255", 32'(ready), 32'd0);
    cycle();
    check("t1_ready_256", 32'(ready), 32'd1);

    // 2. two taken updates at pc 0x40 with zero history
    for (int i = 0; i < 2; i++) begin
      idle(); upd_valid = 1'b1; upd_pc = 16'h0040; upd_hist = 8'h00; upd_taken = 1'b1;
      cycle();
    end
    idle(); pred_pc = 16'h0040;
    cycle();
    check("t2_pred_0x40", 32'(dut_pred), 32'd1);

    // 3. saturation at pc 0x10
    for (int i = 0; i < 5; i++) begin
      idle(); upd_valid = 1'b1; upd_pc = 16'h0010; upd_hist = 8'h00; upd_taken = 1'b1;
      cycle();
    end
    idle(); upd_valid = 1'b1; upd_pc = 16'h0010; upd_hist = 8'h00; upd_taken = 1'b0;
    cycle();
    idle(); pred_pc = 16'h0010;
    cycle();
    check("t3_pred_after_sat", 32'(dut_pred), 32'd1);

    // 4. speculative GHR shifts then mispredict repair
    check("t4_ghr_start", 32'(pred_hist), 32'h00);
    idle(); pred_valid = 1'b1; pred_pc = 16'h0040; cycle();
    check("t4_pred0", 32'(dut_pred), 32'd1);
    idle(); pred_valid = 1'b1; pred_pc = 16'h0041; cycle();
    check("t4_pred1", 32'(dut_pred), 32'd1);
    idle(); pred_valid = 1'b1; pred_pc = 16'h0043; cycle();
    check("t4_pred2", 32'(dut_pred), 32'd1);
    check("t4_ghr_07", 32'(pred_hist), 32'h07);
    idle(); pred_valid = 1'b1; pred_pc = 16'h0040;
    upd_valid = 1'b1; upd_mispredict = 1'b1; upd_pc = 16'h0020; upd_hist = 8'h5A; upd_taken = 1'b1;
    cycle();
    check("t4_ghr_B5", 32'(pred_hist), 32'hB5);

    // 5. alternating branch at 0x80, history fed back from predict
    tail_ok = 0;
    for (int i = 0; i < 64; i++) begin
      outcome = (i % 2 == 0);
      idle(); pred_valid = 1'b1; pred_pc = 16'h0080;
      cycle();
      h = dut_hist;
      p = dut_pred;
      if (i >= 48 && p == outcome) tail_ok++;
      idle(); upd_valid = 1'b1; upd_pc = 16'h0080; upd_hist = h;
      upd_taken = outcome; upd_mispredict = (p != outcome);
      cycle();
    end
    check("t5_last16_correct", 32'(tail_ok), 32'd16);

    // 6. same-cycle predict and update on a fresh pc
    idle(); pred_pc = 16'h0033;
    upd_valid = 1'b1; upd_pc = 16'h0033; upd_hist = 8'(m_ghr); upd_taken = 1'b1;
    cycle();
    check("t6_read_before_write", 32'(dut_pred), 32'd0);
    idle(); pred_pc = 16'h0033;
    cycle();
    check("t6_next_cycle", 32'(dut_pred), 32'd1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      pred_valid     = 1'($urandom_range(0, 1));
      pred_pc        = 16'($urandom_range(0, 7)) | (16'($urandom) & 16'hFF00);
      upd_valid      = 1'($urandom_range(0, 1));
      upd_pc         = 16'($urandom_range(0, 7)) | (16'($urandom) & 16'hFF00);
      upd_hist       = 8'($urandom_range(0, 3));
      upd_taken      = 1'($urandom_range(0, 1));
      upd_mispredict = 1'($urandom_range(0, 3) == 0);
      cycle();
    end

    // reset mid-RUN: tables re-swept, inputs ignored while not ready
    idle();
    reset_pulse();
    for (int i = 0; i < 256; i++) begin
      pred_valid = 1'($urandom_range(0, 1));
      upd_valid  = 1'($urandom_range(0, 1));
      upd_pc     = 16'h0040;
      upd_taken  = 1'b1;
      pred_pc    = 16'h0040;
      cycle();
    end
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_ghr", 32'(pred_hist), 32'h00);
    idle(); pred_pc = 16'h0040;
    cycle();
    check("rst_pred_reinit", 32'(dut_pred), 32'd0);
    for (int i = 0; i < 20; i++) begin
      idle(); pred_pc = 16'($urandom_range(0, 255));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
